// File: rtl/wb_uart_poller.sv
// wb_uart_poller
//   Wishbone classic initiator that services an NS16550-style UART register
//   block without a CPU. It polls ISR, drains RHR into an internal RX FIFO
//   and writes the single-byte TX holding register to THR. Both directions
//   are exposed to fabric logic as valid/ready byte streams.
//
//   Optional feature: define WB_UART_POLLER_TIMEOUT_EN to abort bus cycles
//   that are not acknowledged within TIMEOUT cycles. A timeout sets the
//   sticky bus_err flag. Without the macro, cycles wait for ack forever and
//   bus_err is tied low.
//
//   Ports
//     wb_clk_i, wb_reset_i : clock, synchronous active-high reset
//     wb_adr_o .. wb_ack_i : Wishbone classic initiator (byte lane 0 only)
//     tx_data/valid/ready  : byte stream into the TX holding register
//     rx_data/valid/ready  : byte stream out of the RX FIFO head
//     busy                 : bus cycle in progress (wb_cyc_o)
//     bus_err              : sticky ack-timeout flag
module wb_uart_poller #(
  parameter int unsigned   AW        = 32,
  parameter int unsigned   DW        = 32,
  parameter logic [AW-1:0] BASE_ADDR = '0,
  parameter int unsigned   RX_DEPTH  = 16,
  parameter int unsigned   POLL_GAP  = 64,
  parameter int unsigned   TIMEOUT   = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_reset_i,
  output logic [AW-1:0]   wb_adr_o,
  output logic [DW-1:0]   wb_dat_o,
  input  logic [DW-1:0]   wb_dat_i,
  output logic            wb_we_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  input  logic            wb_ack_i,
  input  logic [7:0]      tx_data,
  input  logic            tx_valid,
  output logic            tx_ready,
  output logic [7:0]      rx_data,
  output logic            rx_valid,
  input  logic            rx_ready,
  output logic            busy,
  output logic            bus_err
);

  localparam int unsigned   PW       = $clog2(RX_DEPTH);
  localparam int unsigned   GW       = $clog2(POLL_GAP + 1);
  localparam logic [PW:0]   FREE_LIM = (PW+1)'(RX_DEPTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);
  localparam logic [AW-1:0] ISR_ADR  = BASE_ADDR | AW'(2);

  typedef enum logic [2:0] {IDLE, RD_ISR, DECIDE, RD_RHR, WR_THR, GAP} state_t;

  state_t          state_q, state_d;
  logic            cyc_q, cyc_d, we_q, we_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic [DW-1:0]   dat_q, dat_d;
  logic [1:0]      isr_q;
  logic            fair_q;
  logic [GW-1:0]   gap_cnt;
  logic [7:0]      hold_data;
  logic            tx_ready_q;
  logic [7:0]      fifo_mem [RX_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     count;
  logic            rx_ok, tx_ok, push, pop, tmo, xfer_done;

  assign rx_ok     = isr_q[0] && (count < FREE_LIM);
  assign tx_ok     = isr_q[1] && !tx_ready_q;
  assign push      = (state_q == RD_RHR) && wb_ack_i;
  assign pop       = rx_valid && rx_ready;
  assign xfer_done = ((state_q == RD_RHR) || (state_q == WR_THR)) && wb_ack_i;

`ifdef WB_UART_POLLER_TIMEOUT_EN
  localparam int unsigned   TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] tmo_cnt;
  logic          bus_err_q;

  assign tmo     = cyc_q && !wb_ack_i && (tmo_cnt == TMO_LAST);
  assign bus_err = bus_err_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_reset_i) begin
      tmo_cnt   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      tmo_cnt <= cyc_q ? tmo_cnt + TW'(1) : '0;
      if (tmo) bus_err_q <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign tmo            = 1'b0;
  assign bus_err        = 1'b0;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  // Only byte lane 0 of read data matters.
  logic unused_dat;
  assign unused_dat = ^wb_dat_i;

  // State register; bus outputs are registered alongside it.
  always_ff @(posedge wb_clk_i) begin
    if (wb_reset_i) begin
      state_q <= IDLE;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= BASE_ADDR;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   state_d = RD_ISR;
      RD_ISR: begin
        if (tmo)           state_d = GAP;
        else if (wb_ack_i) state_d = DECIDE;
      end
      DECIDE: begin
        if (rx_ok && tx_ok) state_d = fair_q ? WR_THR : RD_RHR;
        else if (rx_ok)     state_d = RD_RHR;
        else if (tx_ok)     state_d = WR_THR;
        else                state_d = GAP;
      end
      RD_RHR, WR_THR: begin
        if (tmo)           state_d = GAP;
        else if (wb_ack_i) state_d = IDLE;
      end
      GAP:     if (gap_cnt == GAP_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic, decoded from the next state so the registered bus
  // signals change on the same edge as the state.
  always_comb begin
    cyc_d = (state_d == RD_ISR) || (state_d == RD_RHR) || (state_d == WR_THR);
    we_d  = (state_d == WR_THR);
    adr_d = (state_d == RD_ISR) ? ISR_ADR : BASE_ADDR;
    dat_d = (state_d == WR_THR) ? DW'(hold_data) : '0;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_reset_i) begin
      isr_q      <= '0;
      fair_q     <= 1'b0;
      gap_cnt    <= '0;
      hold_data  <= '0;
      tx_ready_q <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      if ((state_q == RD_ISR) && wb_ack_i) isr_q <= wb_dat_i[1:0];
      if (xfer_done) fair_q <= ~fair_q;
      if ((state_q == GAP) && (gap_cnt != GAP_LAST)) gap_cnt <= gap_cnt + GW'(1);
      else                                           gap_cnt <= '0;

      if (tx_valid && tx_ready_q) begin
        hold_data  <= tx_data;
        tx_ready_q <= 1'b0;
      end else if ((state_q == WR_THR) && wb_ack_i) begin
        tx_ready_q <= 1'b1;
      end

      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + (PW+1)'(1);
      else if (pop && !push) count <= count - (PW+1)'(1);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) fifo_mem[wr_ptr] <= wb_dat_i[7:0];
  end

  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_we_o  = we_q;
  assign wb_sel_o = (DW/8)'(1);
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign busy     = cyc_q;
  assign tx_ready = tx_ready_q;
  assign rx_valid = (count != '0);
  assign rx_data  = fifo_mem[rd_ptr];

endmodule

// File: tb/tb_wb_uart_poller.sv
module tb_wb_uart_poller;

  localparam int unsigned AW       = 32;
  localparam int unsigned DW       = 32;
  localparam int unsigned RX_DEPTH = 8;
  localparam int unsigned POLL_GAP = 8;
  localparam int unsigned TIMEOUT  = 10;
  localparam logic [31:0] BASE     = 32'h0000_0100;
  localparam logic [31:0] ISR_ADR  = 32'h0000_0102;

  logic          clk = 1'b0;
  logic          wb_reset_i = 1'b1;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o, wb_dat_i;
  logic          wb_we_o, wb_cyc_o, wb_stb_o;
  logic [3:0]    wb_sel_o;
  logic          ack = 1'b0;
  logic [7:0]    tx_data = 8'h00;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic [7:0]    rx_data;
  logic          rx_valid, rx_ready;
  logic          busy, bus_err;

  // Responder configuration (written only by the stimulus process)
  logic isr_tx = 1'b0, isr_rx_always = 1'b0, rhr_fixed = 1'b1;
  logic hold_rhr = 1'b0, no_ack = 1'b0;
  logic rx_ready_man = 1'b0, pop_mode = 1'b0;
  int   rhr_base = 0, rhr_limit = 0;

  // Responder / monitor state (written only by the monitor process)
  int          rhr_reads = 0, log_n = 0, pop_n = 0;
  logic [31:0] log_adr [0:1023];
  logic [31:0] log_dat [0:1023];
  logic        log_we  [0:1023];
  logic [3:0]  log_sel [0:1023];
  logic [7:0]  pop_log [0:511];

  int checks = 0, failures = 0;
  int r_snap;

  int         rhr_rel;
  logic [7:0] rhr_byte;
  logic       rx_bit;
  assign rhr_rel  = rhr_reads - rhr_base;
  assign rhr_byte = rhr_fixed ? 8'h41 : rhr_rel[7:0];
  assign rx_bit   = isr_rx_always || (rhr_rel < rhr_limit);
  assign wb_dat_i = (wb_adr_o == ISR_ADR) ? {30'd0, isr_tx, rx_bit} : {24'd0, rhr_byte};
  // In pop_mode the consumer pops exactly on RHR ack cycles, so every push is paired with a pop.
  assign rx_ready = rx_ready_man ||
                    (pop_mode && wb_cyc_o && ack && !wb_we_o && (wb_adr_o == BASE));

  wb_uart_poller #(
    .AW(AW), .DW(DW), .BASE_ADDR(BASE), .RX_DEPTH(RX_DEPTH),
    .POLL_GAP(POLL_GAP), .TIMEOUT(TIMEOUT)
  ) dut (
    .wb_clk_i(clk), .wb_reset_i(wb_reset_i),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o), .wb_ack_i(ack),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .busy(busy), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ack <= wb_cyc_o && wb_stb_o && !ack && !no_ack &&
           !(hold_rhr && !wb_we_o && (wb_adr_o == BASE));
    if (wb_cyc_o && wb_stb_o && ack) begin
      log_adr[log_n % 1024] <= wb_adr_o;
      log_dat[log_n % 1024] <= wb_dat_o;
      log_we[log_n % 1024]  <= wb_we_o;
      log_sel[log_n % 1024] <= wb_sel_o;
      log_n <= log_n + 1;
      if (!wb_we_o && (wb_adr_o == BASE)) rhr_reads <= rhr_reads + 1;
    end
    if (rx_valid && rx_ready) begin
      pop_log[pop_n % 512] <= rx_data;
      pop_n <= pop_n + 1;
    end
  end

  task automatic test_reset();
    wb_reset_i = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (wb_cyc_o !== 1'b0) begin failures++; $display("FAIL reset_cyc got %b exp 0", wb_cyc_o); end
    checks++; if (wb_stb_o !== 1'b0) begin failures++; $display("FAIL reset_stb got %b exp 0", wb_stb_o); end
    checks++; if (wb_we_o !== 1'b0) begin failures++; $display("FAIL reset_we got %b exp 0", wb_we_o); end
    checks++; if (wb_adr_o !== BASE) begin failures++; $display("FAIL reset_adr got %h exp %h", wb_adr_o, BASE); end
    checks++; if (wb_dat_o !== 32'h0) begin failures++; $display("FAIL reset_dat got %h exp 0", wb_dat_o); end
    checks++; if (wb_sel_o !== 4'b0001) begin failures++; $display("FAIL reset_sel got %b exp 0001", wb_sel_o); end
    checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL reset_tx_ready got %b exp 1", tx_ready); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got %b exp 0", rx_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL reset_bus_err got %b exp 0", bus_err); end
  endtask

  task automatic test_poll_idle();
    int l0, first_rise, polls, idle, min_idle, bad, nonisr;
    logic prev;
    isr_tx = 1'b1; isr_rx_always = 1'b0; rhr_limit = 0; rhr_base = rhr_reads;
    l0 = log_n; first_rise = -1; polls = 0; idle = 0; min_idle = 1000; bad = 0; prev = 1'b0;
    wb_reset_i = 1'b0;
    for (int c = 1; c <= 150; c++) begin
      @(negedge clk);
      if (wb_cyc_o && !prev) begin
        if (first_rise < 0) first_rise = c;
        else if (idle < min_idle) min_idle = idle;
        polls++;
        if ((wb_adr_o !== ISR_ADR) || (wb_we_o !== 1'b0)) bad++;
        idle = 0;
      end else if (!wb_cyc_o) begin
        idle++;
      end
      prev = wb_cyc_o;
    end
    nonisr = 0;
    for (int i = l0; i < log_n; i++) if (log_adr[i % 1024] !== ISR_ADR) nonisr++;
    checks++; if (first_rise !== 1) begin failures++; $display("FAIL poll_first_cycle got %0d exp 1", first_rise); end
    checks++; if (polls < 5) begin failures++; $display("FAIL poll_count got %0d exp >=5", polls); end
    checks++; if (min_idle < POLL_GAP) begin failures++; $display("FAIL poll_gap got %0d exp >=%0d", min_idle, POLL_GAP); end
    checks++; if (bad !== 0) begin failures++; $display("FAIL poll_isr_addr got %0d bad exp 0", bad); end
    checks++; if (nonisr !== 0) begin failures++; $display("FAIL poll_no_data_access got %0d exp 0", nonisr); end
  endtask

  task automatic test_rx_tx_alternate();
    int l0, n;
    wb_reset_i = 1'b1;
    repeat (2) @(negedge clk);
    isr_tx = 1'b1; isr_rx_always = 1'b1; rhr_fixed = 1'b1;
    tx_data = 8'h5A; tx_valid = 1'b1;
    l0 = log_n; r_snap = rhr_reads;
    wb_reset_i = 1'b0;
    @(negedge clk);
    tx_valid = 1'b0;
    checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL tx_hold_loaded got %b exp 0", tx_ready); end
    n = 0;
    while ((log_n < l0 + 4) && (n < 300)) begin @(negedge clk); n++; end
    checks++; if (log_n < l0 + 4) begin failures++; $display("FAIL alt_wait got %0d accesses exp 4", log_n - l0); end
    checks++; if ((log_adr[(l0+1)%1024] !== BASE) || (log_we[(l0+1)%1024] !== 1'b0)) begin
      failures++; $display("FAIL alt_rx_first got adr %h we %b exp %h we 0", log_adr[(l0+1)%1024], log_we[(l0+1)%1024], BASE); end
    checks++; if (log_adr[(l0+2)%1024] !== ISR_ADR) begin
      failures++; $display("FAIL alt_isr_between got %h exp %h", log_adr[(l0+2)%1024], ISR_ADR); end
    checks++; if ((log_adr[(l0+3)%1024] !== BASE) || (log_we[(l0+3)%1024] !== 1'b1)) begin
      failures++; $display("FAIL alt_tx_second got adr %h we %b exp %h we 1", log_adr[(l0+3)%1024], log_we[(l0+3)%1024], BASE); end
    checks++; if (log_dat[(l0+3)%1024] !== 32'h0000_005A) begin
      failures++; $display("FAIL thr_data got %h exp 0000005a", log_dat[(l0+3)%1024]); end
    checks++; if (log_sel[(l0+3)%1024] !== 4'b0001) begin
      failures++; $display("FAIL thr_sel got %b exp 0001", log_sel[(l0+3)%1024]); end
    checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL tx_ready_after_ack got %b exp 1", tx_ready); end
    checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL rx_valid_after_read got %b exp 1", rx_valid); end
    checks++; if (rx_data !== 8'h41) begin failures++; $display("FAIL rx_data_first got %h exp 41", rx_data); end
  endtask

  task automatic test_fifo_fill();
    int p0;
    repeat (300) @(negedge clk);
    checks++; if (rhr_reads - r_snap !== RX_DEPTH - 1) begin
      failures++; $display("FAIL fill_rhr_reads got %0d exp %0d", rhr_reads - r_snap, RX_DEPTH - 1); end
    p0 = pop_n;
    rx_ready_man = 1'b1;
    @(negedge clk);
    rx_ready_man = 1'b0;
    checks++; if (pop_n - p0 !== 1) begin failures++; $display("FAIL fill_pop_one got %0d exp 1", pop_n - p0); end
    checks++; if (pop_log[p0 % 512] !== 8'h41) begin failures++; $display("FAIL fill_pop_data got %h exp 41", pop_log[p0 % 512]); end
    repeat (150) @(negedge clk);
    checks++; if (rhr_reads - r_snap !== RX_DEPTH) begin
      failures++; $display("FAIL fill_refill got %0d exp %0d", rhr_reads - r_snap, RX_DEPTH); end
  endtask

  task automatic test_back_to_back_wrap();
    int p0, n, order_errs;
    logic [7:0] exp_b;
    wb_reset_i = 1'b1;
    repeat (2) @(negedge clk);
    isr_tx = 1'b0; isr_rx_always = 1'b0; rhr_fixed = 1'b0;
    rhr_base = rhr_reads; rhr_limit = 40; pop_mode = 1'b0; rx_ready_man = 1'b0;
    p0 = pop_n;
    wb_reset_i = 1'b0;
    n = 0;
    while ((rhr_reads - rhr_base < 3) && (n < 200)) begin @(negedge clk); n++; end
    checks++; if (rhr_reads - rhr_base !== 3) begin failures++; $display("FAIL wrap_prefill got %0d exp 3", rhr_reads - rhr_base); end
    pop_mode = 1'b1;
    n = 0;
    while ((rhr_reads - rhr_base < 40) && (n < 2000)) begin @(negedge clk); n++; end
    pop_mode = 1'b0;
    checks++; if (rhr_reads - rhr_base !== 40) begin failures++; $display("FAIL wrap_reads got %0d exp 40", rhr_reads - rhr_base); end
    checks++; if (pop_n - p0 !== 37) begin failures++; $display("FAIL wrap_paired_pops got %0d exp 37", pop_n - p0); end
    checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL wrap_count_held got %b exp 1", rx_valid); end
    rx_ready_man = 1'b1;
    repeat (6) @(negedge clk);
    rx_ready_man = 1'b0;
    checks++; if (pop_n - p0 !== 40) begin failures++; $display("FAIL wrap_total_pops got %0d exp 40", pop_n - p0); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL wrap_drained got %b exp 0", rx_valid); end
    order_errs = 0;
    for (int i = 0; i < 40; i++) begin
      exp_b = 8'(i);
      if (pop_log[(p0 + i) % 512] !== exp_b) order_errs++;
    end
    checks++; if (order_errs !== 0) begin failures++; $display("FAIL wrap_order got %0d wrong bytes exp 0", order_errs); end
  endtask

  task automatic test_reset_mid_cycle();
    int n;
    wb_reset_i = 1'b1;
    repeat (2) @(negedge clk);
    isr_tx = 1'b0; isr_rx_always = 1'b1; rhr_fixed = 1'b1; hold_rhr = 1'b0;
    tx_data = 8'hC3; tx_valid = 1'b1;
    r_snap = rhr_reads;
    wb_reset_i = 1'b0;
    @(negedge clk);
    tx_valid = 1'b0;
    n = 0;
    while ((rhr_reads - r_snap < 2) && (n < 100)) begin @(negedge clk); n++; end
    hold_rhr = 1'b1;
    n = 0;
    while (!(wb_cyc_o && !wb_we_o && (wb_adr_o == BASE)) && (n < 50)) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    checks++; if (wb_cyc_o !== 1'b1) begin failures++; $display("FAIL midrst_rhr_waiting got %b exp 1", wb_cyc_o); end
    checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL midrst_fifo_before got %b exp 1", rx_valid); end
    checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL midrst_tx_held got %b exp 0", tx_ready); end
    wb_reset_i = 1'b1;
    @(negedge clk);
    checks++; if (wb_cyc_o !== 1'b0) begin failures++; $display("FAIL midrst_cyc got %b exp 0", wb_cyc_o); end
    checks++; if (wb_stb_o !== 1'b0) begin failures++; $display("FAIL midrst_stb got %b exp 0", wb_stb_o); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got %b exp 0", busy); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL midrst_fifo_empty got %b exp 0", rx_valid); end
    checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL midrst_tx_ready got %b exp 1", tx_ready); end
    hold_rhr = 1'b0;
  endtask

`ifdef WB_UART_POLLER_TIMEOUT_EN
  task automatic test_timeout();
    int n, l0;
    wb_reset_i = 1'b1;
    repeat (2) @(negedge clk);
    isr_tx = 1'b0; isr_rx_always = 1'b0; rhr_limit = 0; rhr_base = rhr_reads; no_ack = 1'b1;
    wb_reset_i = 1'b0;
    n = 0;
    while (!wb_cyc_o && (n < 10)) begin @(negedge clk); n++; end
    n = 0;
    while (wb_cyc_o && (n < 50)) begin n++; @(negedge clk); end
    checks++; if (n !== TIMEOUT) begin failures++; $display("FAIL tmo_cycles got %0d exp %0d", n, TIMEOUT); end
    checks++; if (bus_err !== 1'b1) begin failures++; $display("FAIL tmo_bus_err got %b exp 1", bus_err); end
    no_ack = 1'b0;
    l0 = log_n;
    n = 0;
    while ((log_n < l0 + 2) && (n < 200)) begin @(negedge clk); n++; end
    checks++; if (log_n < l0 + 2) begin failures++; $display("FAIL tmo_recover got %0d accesses exp 2", log_n - l0); end
    checks++; if (bus_err !== 1'b1) begin failures++; $display("FAIL tmo_sticky got %b exp 1", bus_err); end
  endtask
`else
  task automatic test_no_timeout();
    wb_reset_i = 1'b1;
    repeat (2) @(negedge clk);
    isr_tx = 1'b0; isr_rx_always = 1'b0; rhr_limit = 0; rhr_base = rhr_reads; no_ack = 1'b1;
    wb_reset_i = 1'b0;
    repeat (300) @(negedge clk);
    checks++; if (wb_cyc_o !== 1'b1) begin failures++; $display("FAIL notmo_waits got %b exp 1", wb_cyc_o); end
    checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL notmo_bus_err got %b exp 0", bus_err); end
    no_ack = 1'b0;
    repeat (5) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_poll_idle();
    test_rx_tx_alternate();
    test_fifo_fill();
    test_back_to_back_wrap();
    test_reset_mid_cycle();
`ifdef WB_UART_POLLER_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
